// File: rtl/action_selector.sv
// action_selector: epsilon-greedy policy stage for the double-Q datapath.
// Captures four signed Q16.16 values and an exploration threshold, finds the
// argmax with one signed comparator over three cycles, then reports the greedy
// action/value and the action actually taken (random when the LFSR value is at
// or below epsilon).
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   in_valid/in_ready input handshake (in_ready = state is IDLE)
//   Q0..Q3            signed Q16.16 Q-values for actions 0..3
//   epsilon           unsigned exploration threshold
//   out_valid/ready   output handshake
//   A                 action taken
//   Amax, Qmax        greedy action and its value
//   explore           1 when A came from the LFSR
module action_selector #(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int unsigned RAND_LSB = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Q0,
  input  logic [31:0] Q1,
  input  logic [31:0] Q2,
  input  logic [31:0] Q3,
  input  logic [15:0] epsilon,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  A,
  output logic [1:0]  Amax,
  output logic [31:0] Qmax,
  output logic        explore
);

  localparam int unsigned QW = 32;
  localparam int unsigned EW = 16;
  localparam int unsigned AW = 2;
  localparam int unsigned LW = 16;
  localparam logic [LW-1:0] TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMP1 = 3'd1,
    CMP2 = 3'd2,
    CMP3 = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic signed [QW-1:0] q1_q, q1_d;
  logic signed [QW-1:0] q2_q, q2_d;
  logic signed [QW-1:0] q3_q, q3_d;
  logic [EW-1:0]        eps_q, eps_d;
  logic signed [QW-1:0] best_val_q, best_val_d;
  logic [AW-1:0]        best_idx_q, best_idx_d;
  logic                 out_valid_q, out_valid_d;
  logic [AW-1:0]        a_q, a_d;
  logic [AW-1:0]        amax_q, amax_d;
  logic [QW-1:0]        qmax_q, qmax_d;
  logic                 explore_q, explore_d;
  logic [LW-1:0]        lfsr_q, lfsr_d;

  // Shared comparator datapath
  logic signed [QW-1:0] cmp_val;
  logic [AW-1:0]        cmp_idx;
  logic                 cmp_gt;
  logic signed [QW-1:0] fin_val;
  logic [AW-1:0]        fin_idx;
  logic                 explore_c;
  logic [AW-1:0]        rand_act;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign A         = a_q;
  assign Amax      = amax_q;
  assign Qmax      = qmax_q;
  assign explore   = explore_q;

  // Select the candidate for this compare cycle; strict > keeps the lower index on ties
  always_comb begin
    cmp_val = q1_q;
    cmp_idx = AW'(1);
    case (state_q)
      CMP2: begin
        cmp_val = q2_q;
        cmp_idx = AW'(2);
      end
      CMP3: begin
        cmp_val = q3_q;
        cmp_idx = AW'(3);
      end
      default: begin
        cmp_val = q1_q;
        cmp_idx = AW'(1);
      end
    endcase
    cmp_gt  = (cmp_val > best_val_q);
    fin_val = cmp_gt ? cmp_val : best_val_q;
    fin_idx = cmp_gt ? cmp_idx : best_idx_q;
  end

  // Galois LFSR step and exploration decision (LFSR is never zero)
  always_comb begin
    lfsr_d    = {1'b0, lfsr_q[LW-1:1]} ^ (lfsr_q[0] ? TAPS : LW'(0));
    explore_c = (lfsr_q <= eps_q);
    rand_act  = lfsr_q[RAND_LSB +: AW];
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    q1_d        = q1_q;
    q2_d        = q2_q;
    q3_d        = q3_q;
    eps_d       = eps_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    amax_d      = amax_q;
    qmax_d      = qmax_q;
    explore_d   = explore_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q1_d       = Q1;
          q2_d       = Q2;
          q3_d       = Q3;
          eps_d      = epsilon;
          best_val_d = Q0;
          best_idx_d = AW'(0);
          state_d    = CMP1;
        end
      end
      CMP1: begin
        best_val_d = fin_val;
        best_idx_d = fin_idx;
        state_d    = CMP2;
      end
      CMP2: begin
        best_val_d = fin_val;
        best_idx_d = fin_idx;
        state_d    = CMP3;
      end
      CMP3: begin
        best_val_d  = fin_val;
        best_idx_d  = fin_idx;
        amax_d      = fin_idx;
        qmax_d      = fin_val;
        explore_d   = explore_c;
        a_d         = explore_c ? rand_act : fin_idx;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // Result is held until the consumer takes it
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      q1_q        <= '0;
      q2_q        <= '0;
      q3_q        <= '0;
      eps_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      amax_q      <= '0;
      qmax_q      <= '0;
      explore_q   <= 1'b0;
      lfsr_q      <= SEED;
    end else begin
      state_q     <= state_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
      q3_q        <= q3_d;
      eps_q       <= eps_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      amax_q      <= amax_d;
      qmax_q      <= qmax_d;
      explore_q   <= explore_d;
      lfsr_q      <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_action_selector.sv
// Directed bench for action_selector: argmax, signed ties, exploration,
// back-pressure, mid-operation reset and back-to-back throughput.
module tb_action_selector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] Q0 = '0, Q1 = '0, Q2 = '0, Q3 = '0;
  logic [15:0] epsilon = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  A, Amax;
  logic [31:0] Qmax;
  logic        explore;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference LFSR: ref_prev holds the value that was present before the last edge
  logic [15:0] ref_lfsr, ref_prev;

  action_selector #(.SEED(16'hACE1), .RAND_LSB(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .epsilon(epsilon),
    .out_valid(out_valid), .out_ready(out_ready),
    .A(A), .Amax(Amax), .Qmax(Qmax), .explore(explore)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_lfsr <= 16'hACE1;
      ref_prev <= 16'hACE1;
    end else begin
      ref_prev <= ref_lfsr;
      ref_lfsr <= (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [15:0] e);
    Q0 = a; Q1 = b; Q2 = c; Q3 = d; epsilon = e;
    in_valid = 1'b1;
  endtask

  // Present one vector, drop in_valid and scramble inputs after the accept edge,
  // then count edges (from presentation) until out_valid rises.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d,
                         input logic [15:0] e, output int lat);
    present(a, b, c, d, e);
    tick();
    in_valid = 1'b0;
    Q0 = 32'h7FFF_FFFF; Q1 = 32'h7FFF_FFFF; Q2 = 32'h7FFF_FFFF; Q3 = 32'h7FFF_FFFF;
    epsilon = ~e;
    lat = 1;
    while (!out_valid && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (A !== 2'd0 || Amax !== 2'd0) begin failures++; $display("FAIL reset_actions got A=%0d Amax=%0d want 0 0", A, Amax); end
    checks++; if (Qmax !== 32'h0 || explore !== 1'b0) begin failures++; $display("FAIL reset_qmax_explore got Qmax=%h explore=%b want 0 0", Qmax, explore); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ascending();
    int lat;
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL asc_in_ready_before got=%b want=1", in_ready); end
    run_one(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 16'h0000, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL asc_latency got=%0d want=4", lat); end
    checks++; if (Amax !== 2'd3) begin failures++; $display("FAIL asc_amax got=%0d want=3", Amax); end
    checks++; if (Qmax !== 32'h0000_4000) begin failures++; $display("FAIL asc_qmax got=%h want=00004000", Qmax); end
    checks++; if (A !== 2'd3 || explore !== 1'b0) begin failures++; $display("FAIL asc_action got A=%0d explore=%b want 3 0", A, explore); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL asc_in_ready_done got=%b want=0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL asc_consume got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_signed_ties();
    int lat;
    out_ready = 1'b1;
    run_one(32'hFFFB_0000, 32'hFFF6_0000, 32'hFFFB_0000, 32'h8000_0000, 16'h0000, lat);
    checks++; if (Amax !== 2'd0) begin failures++; $display("FAIL tie_amax got=%0d want=0", Amax); end
    checks++; if (Qmax !== 32'hFFFB_0000) begin failures++; $display("FAIL tie_qmax got=%h want=fffb0000", Qmax); end
    checks++; if (A !== 2'd0 || explore !== 1'b0) begin failures++; $display("FAIL tie_action got A=%0d explore=%b want 0 0", A, explore); end
    tick();
    run_one(32'hFFFB_0000, 32'h0005_0000, 32'hFFF6_0000, 32'h8000_0000, 16'h0000, lat);
    checks++; if (Amax !== 2'd1) begin failures++; $display("FAIL pos_amax got=%0d want=1", Amax); end
    checks++; if (Qmax !== 32'h0005_0000) begin failures++; $display("FAIL pos_qmax got=%h want=00050000", Qmax); end
    checks++; if (A !== 2'd1) begin failures++; $display("FAIL pos_action got=%0d want=1", A); end
    tick();
  endtask

  task automatic test_explore();
    int lat;
    logic [1:0] exp_a;
    logic exp_x;
    out_ready = 1'b1;
    run_one(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 16'hFFFF, lat);
    exp_a = ref_prev[9:8];
    checks++; if (explore !== 1'b1) begin failures++; $display("FAIL explore_flag got=%b want=1", explore); end
    checks++; if (A !== exp_a) begin failures++; $display("FAIL explore_action got=%0d want=%0d", A, exp_a); end
    checks++; if (Amax !== 2'd3 || Qmax !== 32'h0000_4000) begin failures++; $display("FAIL explore_greedy got Amax=%0d Qmax=%h want 3 00004000", Amax, Qmax); end
    tick();
    // Mid-range threshold: decision follows the reference LFSR value
    run_one(32'h0000_0010, 32'h0000_0030, 32'h0000_0020, 32'h0000_0000, 16'h8000, lat);
    exp_x = (ref_prev <= 16'h8000);
    exp_a = exp_x ? ref_prev[9:8] : 2'd1;
    checks++; if (explore !== exp_x || A !== exp_a) begin failures++; $display("FAIL eps_mid got explore=%b A=%0d want %b %0d", explore, A, exp_x, exp_a); end
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [1:0] exp_a;
    bit stable;
    out_ready = 1'b0;
    run_one(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 16'hFFFF, lat);
    exp_a = ref_prev[9:8];
    checks++; if (A !== exp_a || explore !== 1'b1) begin failures++; $display("FAIL bp_first got A=%0d explore=%b want %0d 1", A, explore, exp_a); end
    // A competing request during the stall must be ignored
    present(32'h0000_9000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 16'h0000);
    stable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || A !== exp_a || Amax !== 2'd3 ||
          Qmax !== 32'h0000_4000 || explore !== 1'b1) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_hold got A=%0d Amax=%0d Qmax=%h explore=%b in_ready=%b want %0d 3 00004000 1 0", A, Amax, Qmax, explore, in_ready, exp_a); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL bp_no_accept got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit stale;
    out_ready = 1'b1;
    present(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 16'h0000);
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_cmp2 got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    checks++; if (dut.lfsr_q !== 16'hACE1) begin failures++; $display("FAIL rst_lfsr got=%h want=ace1", dut.lfsr_q); end
    tick();
    rst = 1'b1;
    tick();
    // Abort while holding a result in DONE
    out_ready = 1'b0;
    run_one(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 16'h0000, lat);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rst_done got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin failures++; $display("FAIL rst_stale got=%b want=0", stale); end
    run_one(32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'h0000_4000, 16'h0000, lat);
    checks++; if (lat !== 4 || Amax !== 2'd3 || Qmax !== 32'h0000_4000 || A !== 2'd3 || explore !== 1'b0) begin
      failures++; $display("FAIL rst_after got lat=%0d Amax=%0d Qmax=%h A=%0d explore=%b want 4 3 00004000 3 0", lat, Amax, Qmax, A, explore);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] bq [0:3][0:3];
    logic [15:0] be [0:3];
    logic [1:0]  bamax [0:3];
    logic [31:0] bqmax [0:3];
    logic [1:0]  exp_a;
    logic        exp_x;
    int n, t, t_prev;
    bq[0][0] = 32'd7;         bq[0][1] = 32'd9;         bq[0][2] = 32'd9;         bq[0][3] = 32'd2;
    be[0] = 16'h0000; bamax[0] = 2'd1; bqmax[0] = 32'd9;
    bq[1][0] = 32'hFFFF_FFFF; bq[1][1] = 32'hFFFF_FFFE; bq[1][2] = 32'hFFFF_FFFD; bq[1][3] = 32'hFFFF_FFFC;
    be[1] = 16'h8000; bamax[1] = 2'd0; bqmax[1] = 32'hFFFF_FFFF;
    bq[2][0] = 32'h7FFF_FFFF; bq[2][1] = 32'h0;         bq[2][2] = 32'h8000_0000; bq[2][3] = 32'h7FFF_FFFF;
    be[2] = 16'hFFFF; bamax[2] = 2'd0; bqmax[2] = 32'h7FFF_FFFF;
    bq[3][0] = 32'h8000_0000; bq[3][1] = 32'h8000_0001; bq[3][2] = 32'h0;         bq[3][3] = 32'hFFFF_FFFF;
    be[3] = 16'h4000; bamax[3] = 2'd2; bqmax[3] = 32'h0;
    out_ready = 1'b1;
    t_prev = 0;
    present(bq[0][0], bq[0][1], bq[0][2], bq[0][3], be[0]);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) present(bq[k+1][0], bq[k+1][1], bq[k+1][2], bq[k+1][3], be[k+1]);
      else in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 12) begin
        tick();
        n++;
      end
      t = cyc;
      exp_x = (ref_prev <= be[k]);
      exp_a = exp_x ? ref_prev[9:8] : bamax[k];
      checks++; if (Amax !== bamax[k] || Qmax !== bqmax[k]) begin failures++; $display("FAIL b2b_greedy_%0d got Amax=%0d Qmax=%h want %0d %h", k, Amax, Qmax, bamax[k], bqmax[k]); end
      checks++; if (A !== exp_a || explore !== exp_x) begin failures++; $display("FAIL b2b_action_%0d got A=%0d explore=%b want %0d %b", k, A, explore, exp_a, exp_x); end
      if (k > 0) begin
        checks++; if (t - t_prev !== 5) begin failures++; $display("FAIL b2b_period_%0d got=%0d want=5", k, t - t_prev); end
      end
      t_prev = t;
      tick();
      if (k < 3) tick();
    end
  endtask

  initial begin
    test_reset();
    test_ascending();
    test_signed_ties();
    test_explore();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
